lcd_readback_dma: RTL and testbench
===================================

# lcd_readback_dma

- Reads frame data back out of the LCD controller's GRAM over the 8-bit 8080-style parallel bus and writes it to system memory through an AXI4 master write channel.
- It is the read-direction counterpart of the frame-push DMA: same bus timing, byte-lane order, burst size and frame geometry.
- It sits beside the LCD control block and shares its register interface and the LCD pins through the top-level mux (`busy` selects this block).

## Interface

Parameters:

- LEN, 16: beats per AXI write burst (32-bit words).
- CYC, 2400: bursts per frame (16 × 2400 × 4 B = 320 × 240 × 16-bit pixels).
- BYTE_CYC, 10: clocks per LCD read strobe period.
- RD_LO, 3: phase count at which lcd_rd_n falls.
- RD_HI, 8: phase count at which lcd_rd_n rises; data is sampled on this edge.
- FIFO_DEPTH, 64: words of internal buffer; must be ≥ 2×LEN and a power of 2.

Ports:

- M_AXI_ACLK, in, 1: clock.
- M_AXI_ARESETN, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle request; ignored while busy.
- dest_address, in, 32: frame base; sampled on start; LEN×4-aligned.
- busy, out, 1: transfer in progress; LCD pins owned by this block.
- done, out, 1: one-cycle pulse on final BVALID.
- err, out, 1: sticky, set by any BRESP ≠ OKAY; cleared on start.
- lcd_cs_n, out, 1: chip select.
- lcd_rs, out, 1: register select, held 1 (data) while busy.
- lcd_rd_n, out, 1: read strobe.
- lcd_data_oe, out, 1: bus drive enable, 0 while busy.
- lcd_data_in, in, 8: LCD data bus.
- M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWCACHE/AWVALID, out: write address; AWLEN = LEN−1, AWSIZE = 2, AWBURST = INCR, AWCACHE = 3.
- M_AXI_AWREADY, in.
- M_AXI_WDATA[31:0], M_AXI_WSTRB = 4'hF, M_AXI_WLAST, M_AXI_WVALID, out.
- M_AXI_WREADY, in.
- M_AXI_BRESP[1:0], M_AXI_BVALID, in.
- M_AXI_BREADY, out: constant 1.

## Operation

**Reset values**
- busy, done, err, AWVALID, WVALID, WLAST = 0.
- lcd_cs_n, lcd_rd_n, lcd_rs, lcd_data_oe = 1.
- AWADDR = 0; FIFO empty.

**LCD side** (states L_IDLE, L_RUN)
- On start: enter L_RUN, drive lcd_cs_n = 0 and lcd_data_oe = 0, clear phase counter, byte index, byte count and err.
- Phase counter runs 0..BYTE_CYC−1.
- lcd_rd_n goes 0 at phase RD_LO and 1 at phase RD_HI.
- lcd_data_in is captured in the cycle lcd_rd_n rises.
- Byte k of each word goes to lane order 1, 0, 3, 2, i.e. bits [15:8], [7:0], [31:24], [23:16]. This matches pixel-halfword order in memory.
- After the 4th byte, the word is pushed into the FIFO.
- Phase counter holds at 0 (no new strobe) while the FIFO has fewer than 1 free entry.
- After LEN×CYC words are pushed: lcd_cs_n = 1, return to L_IDLE.

**AXI side** (states A_IDLE, A_ADDR, A_DATA, A_RESP)
- A_IDLE → A_ADDR when FIFO count ≥ LEN and bursts issued < CYC.
- A_ADDR: AWVALID = 1 with AWADDR held; on AWREADY go to A_DATA.
- A_DATA: WVALID = 1 with WDATA = FIFO head; pop on WREADY. WLAST = 1 on beat LEN−1; after it is accepted go to A_RESP.
- A_RESP: wait for BVALID, OR the BRESP error into err, then AWADDR += LEN×4.
  - Last burst: pulse done, drop busy, return to A_IDLE.
  - Otherwise: return to A_IDLE.
- One burst outstanding at a time; AW always precedes W.
- busy = 1 from the cycle after start until the cycle done pulses.

**Boundaries**
- start while busy: no effect.
- FIFO full: LCD strobing stalls at the byte boundary; there is no overflow.
- FIFO push and pop in the same cycle: count is unchanged.
- AWADDR wraps modulo 2^32.
- Async reset mid-frame: immediate return to reset values; any AXI burst in flight is abandoned.

## Timing

- First lcd_rd_n fall: RD_LO+1 cycles after start.
- Byte rate: one per BYTE_CYC cycles when not stalled.
- AWVALID rises the cycle after FIFO count reaches LEN.
- With WREADY held 1, the LEN beats are issued on LEN consecutive cycles.
- done pulses the cycle after the final BVALID; busy drops in that same cycle.

## Configuration

- `LCD_RB_DUMMY_EN` defined: the first strobed byte after start is discarded (controller dummy read), so LEN×CYC×4+1 strobes are issued per frame.
- Undefined: every strobed byte is stored, giving exactly LEN×CYC×4 strobes.

## Test plan

All scenarios use LEN=4, CYC=3, BYTE_CYC=10.

1. **Reset:** assert ARESETN=0 mid-frame → all outputs return to reset values in the same cycle, and a new start afterwards runs cleanly.
2. **Byte packing:** bytes 0x11, 0x22, 0x33, 0x44 → first WDATA = 0x33441122.
3. **Full frame:** dest_address = 0x1000_0000, AWREADY/WREADY = 1 → three bursts at 0x10000000, 0x10000010 and 0x10000020; WLAST on every 4th beat; done once; 48 rd_n strobes (49 with `LCD_RB_DUMMY_EN`).
4. **Backpressure:** WREADY = 0 for 2000 cycles → strobing stalls once the FIFO is full; no data is lost or duplicated; memory image matches the incrementing byte pattern.
5. **Error and start filtering:** BRESP = 2'b10 on burst 2 → err = 1 after the transfer and cleared by the next start; start pulsed while busy → ignored.

Source files
------------

// File: rtl/lcd_readback_dma.sv
`timescale 1ns/1ps
// ============================================================================
// lcd_readback_dma
// ----------------------------------------------------------------------------
// Reads frame data out of the LCD controller's GRAM over the 8-bit 8080-style
// parallel bus and writes it to system memory as AXI4 INCR write bursts.
// This is the read-direction twin of the frame-push DMA. It uses the same
// strobe timing, byte-lane order, burst size and frame geometry.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN  clock, asynchronous active-low reset
//   start, dest_address        one-cycle request and frame base address
//   busy, done, err            transfer status (err is sticky until start)
//   lcd_cs_n, lcd_rs,          LCD bus control; lcd_data_oe = 0 while busy
//   lcd_rd_n, lcd_data_oe
//   lcd_data_in                LCD data bus input
//   M_AXI_AW*/W*/B*            AXI4 master write channels
//
// Configuration
//   LCD_RB_DUMMY_EN  When defined, the first strobed byte after start is
//                    treated as the controller's dummy read and discarded.
// ============================================================================
module lcd_readback_dma #(
    parameter int LEN        = 16,
    parameter int CYC        = 2400,
    parameter int BYTE_CYC   = 10,
    parameter int RD_LO      = 3,
    parameter int RD_HI      = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        start,
    input  logic [31:0] dest_address,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_rd_n,
    output logic        lcd_data_oe,
    input  logic [7:0]  lcd_data_in,
    output logic [31:0] M_AXI_AWADDR,
    output logic [7:0]  M_AXI_AWLEN,
    output logic [2:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic [3:0]  M_AXI_AWCACHE,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WLAST,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY
);

    localparam int PH_W  = (BYTE_CYC > 1) ? $clog2(BYTE_CYC) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] FRAME_WORDS = 32'(LEN * CYC);
    localparam logic [31:0] BURST_BYTES = 32'(LEN * 4);

    typedef enum logic {L_IDLE, L_RUN} lcdState_t;
    typedef enum logic [1:0] {A_IDLE, A_ADDR, A_DATA, A_RESP} axiState_t;

    lcdState_t        r_lState;
    logic [PH_W-1:0]  r_phase;
    logic [1:0]       r_byteIdx;
    logic [31:0]      r_wordCnt;
    logic [31:0]      r_word;
    logic             r_csN;
    logic             r_rdN;
`ifdef LCD_RB_DUMMY_EN
    logic             r_dummy;
`endif

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    axiState_t        r_aState;
    logic [31:0]      r_awaddr;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             r_wlast;
    logic [7:0]       r_beat;
    logic [31:0]      r_burstCnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_oe;

    logic             w_startAccept;
    logic             w_fifoFull;
    logic             w_capture;
    logic             w_storeByte;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pushData;

    assign w_startAccept = start && !r_busy;
    assign w_fifoFull    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_capture     = (r_lState == L_RUN) && (r_phase == PH_W'(RD_HI));
`ifdef LCD_RB_DUMMY_EN
    assign w_storeByte   = w_capture && !r_dummy;
`else
    assign w_storeByte   = w_capture;
`endif
    // The 4th byte bypasses r_word and lands in lane [23:16] on its way into the FIFO.
    assign w_push        = w_storeByte && (r_byteIdx == 2'd3);
    assign w_pushData    = {r_word[31:24], lcd_data_in, r_word[15:0]};
    assign w_pop         = (r_aState == A_DATA) && r_wvalid && M_AXI_WREADY;

    // LCD side: generates the read strobe and packs bytes into words.
    // Strobing pauses at phase 0 while the FIFO is full, so a byte is never
    // started unless its word is guaranteed a free slot.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_lState  <= L_IDLE;
            r_phase   <= '0;
            r_byteIdx <= 2'd0;
            r_wordCnt <= 32'd0;
            r_word    <= 32'd0;
            r_csN     <= 1'b1;
            r_rdN     <= 1'b1;
`ifdef LCD_RB_DUMMY_EN
            r_dummy   <= 1'b0;
`endif
        end else if (w_startAccept) begin
            r_lState  <= L_RUN;
            r_phase   <= '0;
            r_byteIdx <= 2'd0;
            r_wordCnt <= 32'd0;
            r_word    <= 32'd0;
            r_csN     <= 1'b0;
            r_rdN     <= 1'b1;
`ifdef LCD_RB_DUMMY_EN
            r_dummy   <= 1'b1;
`endif
        end else if (r_lState == L_RUN) begin
            if ((r_phase == '0) && w_fifoFull) begin
                r_phase <= '0;
            end else if (r_phase == PH_W'(BYTE_CYC - 1)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end

            if (r_phase == PH_W'(RD_LO)) begin
                r_rdN <= 1'b0;
            end

            if (w_capture) begin
                r_rdN <= 1'b1;
            end

`ifdef LCD_RB_DUMMY_EN
            if (w_capture && r_dummy) begin
                r_dummy <= 1'b0;
            end
`endif

            if (w_storeByte) begin
                case (r_byteIdx)
                    2'd0:    r_word[15:8]  <= lcd_data_in;
                    2'd1:    r_word[7:0]   <= lcd_data_in;
                    2'd2:    r_word[31:24] <= lcd_data_in;
                    default: r_word[23:16] <= lcd_data_in;
                endcase
                r_byteIdx <= r_byteIdx + 2'd1;
            end

            if (w_push) begin
                r_wordCnt <= r_wordCnt + 32'd1;
                if (r_wordCnt == FRAME_WORDS - 32'd1) begin
                    r_lState <= L_IDLE;
                    r_csN    <= 1'b1;
                end
            end
        end
    end

    // FIFO storage. There is no reset, because a cleared pointer pair already means empty.
    always_ff @(posedge M_AXI_ACLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushData;
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // AXI side: one burst in flight at a time, with address before data.
    // A burst is only requested once a full burst of words is buffered, so
    // the FIFO can never run dry in the middle of a burst.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_aState   <= A_IDLE;
            r_awaddr   <= 32'd0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_wlast    <= 1'b0;
            r_beat     <= 8'd0;
            r_burstCnt <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_oe       <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_startAccept) begin
                r_aState   <= A_IDLE;
                r_busy     <= 1'b1;
                r_err      <= 1'b0;
                r_oe       <= 1'b0;
                r_awaddr   <= dest_address;
                r_burstCnt <= 32'd0;
                r_awvalid  <= 1'b0;
                r_wvalid   <= 1'b0;
                r_wlast    <= 1'b0;
            end else begin
                case (r_aState)
                    A_IDLE: begin
                        if (r_busy && (r_count >= CNT_W'(LEN)) && (r_burstCnt < 32'(CYC))) begin
                            r_awvalid <= 1'b1;
                            r_aState  <= A_ADDR;
                        end
                    end
                    A_ADDR: begin
                        if (M_AXI_AWREADY) begin
                            r_awvalid  <= 1'b0;
                            r_wvalid   <= 1'b1;
                            r_beat     <= 8'd0;
                            r_wlast    <= (LEN == 1);
                            r_burstCnt <= r_burstCnt + 32'd1;
                            r_aState   <= A_DATA;
                        end
                    end
                    A_DATA: begin
                        if (M_AXI_WREADY) begin
                            if (r_beat == 8'(LEN - 1)) begin
                                r_wvalid <= 1'b0;
                                r_wlast  <= 1'b0;
                                r_aState <= A_RESP;
                            end else begin
                                r_beat  <= r_beat + 8'd1;
                                r_wlast <= (r_beat == 8'(LEN - 2));
                            end
                        end
                    end
                    default: begin
                        if (M_AXI_BVALID) begin
                            r_err    <= r_err | (M_AXI_BRESP != 2'b00);
                            r_awaddr <= r_awaddr + BURST_BYTES;
                            r_aState <= A_IDLE;
                            if (r_burstCnt == 32'(CYC)) begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                                r_oe   <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign lcd_cs_n      = r_csN;
    assign lcd_rs        = 1'b1;
    assign lcd_rd_n      = r_rdN;
    assign lcd_data_oe   = r_oe;

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = 8'(LEN - 1);
    assign M_AXI_AWSIZE  = 3'd2;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWCACHE = 4'd3;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_mem[r_rdPtr];
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WLAST   = r_wlast;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = 1'b1;

endmodule

// File: tb/tb_lcd_readback_dma.sv
`timescale 1ns/1ps
// ============================================================================
// tb_lcd_readback_dma
// ----------------------------------------------------------------------------
// Bench for lcd_readback_dma with LEN=4, CYC=3 and BYTE_CYC=10. An LCD model
// serves a known byte pattern on each read strobe and pushes the word it
// expects to see into a queue. An AXI slave model accepts the bursts, and a
// monitor pops and compares the queued words and addresses as beats are
// accepted. Honours LCD_RB_DUMMY_EN when it is defined.
// ============================================================================
module tb_lcd_readback_dma;

    localparam int LEN        = 4;
    localparam int CYC        = 3;
    localparam int BYTE_CYC   = 10;
    localparam int RD_LO      = 3;
    localparam int RD_HI      = 8;
    localparam int FIFO_DEPTH = 8;
`ifdef LCD_RB_DUMMY_EN
    localparam int DUMMY = 1;
`else
    localparam int DUMMY = 0;
`endif
    localparam int STROBES = LEN * CYC * 4 + DUMMY;

    logic        clock = 1'b0;
    logic        aresetn;
    logic        start;
    logic [31:0] destAddress;
    logic        busy, done, err;
    logic        lcdCsN, lcdRs, lcdRdN, lcdDataOe;
    logic [7:0]  lcdDataIn;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCnt   = 0;

    logic [31:0] expData[$];
    logic [31:0] expAddr[$];
    logic [31:0] accWord;
    logic [7:0]  modelByte;
    int          modelN;
    int          strobeCnt, firstFallCycle, startCycle;
    int          beatTotal, beatInBurst, lastBeatCycle, doneCnt;
    int          burstIdx, errBurst;
    bit          bPending, consecCheck, firstAw;

    lcd_readback_dma #(
        .LEN(LEN), .CYC(CYC), .BYTE_CYC(BYTE_CYC),
        .RD_LO(RD_LO), .RD_HI(RD_HI), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .M_AXI_ACLK(clock), .M_AXI_ARESETN(aresetn),
        .start(start), .dest_address(destAddress),
        .busy(busy), .done(done), .err(err),
        .lcd_cs_n(lcdCsN), .lcd_rs(lcdRs), .lcd_rd_n(lcdRdN),
        .lcd_data_oe(lcdDataOe), .lcd_data_in(lcdDataIn),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    // Free-running clock and a cycle counter used for the latency checks.
    always #5 clock = ~clock;
    always @(posedge clock) cycleCnt++;

    // Compare one observed value against its expected value and keep the tallies.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // LCD model: each falling strobe presents the next pattern byte, where
    // byte n is 0x11*(n+1). Each completed word is queued in memory lane order.
    always @(negedge lcdRdN) begin
        if (strobeCnt == 0) firstFallCycle = cycleCnt;
        if (strobeCnt < DUMMY) begin
            lcdDataIn = 8'hEE;
        end else begin
            modelN    = strobeCnt - DUMMY;
            modelByte = 8'(17 * (modelN + 1));
            case (modelN % 4)
                0: accWord[15:8]  = modelByte;
                1: accWord[7:0]   = modelByte;
                2: accWord[31:24] = modelByte;
                default: begin
                    accWord[23:16] = modelByte;
                    expData.push_back(accWord);
                end
            endcase
            lcdDataIn = modelByte;
        end
        strobeCnt++;
    end

    // AXI write-response model: one BVALID beat after each WLAST. The burst
    // selected by errBurst answers with SLVERR.
    initial begin
        bvalid = 1'b0;
        bresp  = 2'b00;
        forever begin
            @(posedge clock);
            #1;
            if (!aresetn) begin
                bvalid = 1'b0;
            end else if (bvalid) begin
                bvalid = 1'b0;
            end else if (bPending) begin
                bvalid   = 1'b1;
                bresp    = (burstIdx == errBurst) ? 2'b10 : 2'b00;
                burstIdx++;
                bPending = 1'b0;
            end
        end
    end

    // Monitor: the signals are stable at the falling edge and show what the
    // next rising edge will transfer.
    always @(negedge clock) begin
        if (aresetn) begin
            if (awvalid && awready) begin
                checkOutput("aw_expected", 32'(expAddr.size() != 0), 32'd1);
                if (expAddr.size() != 0) checkOutput("awaddr", awaddr, expAddr.pop_front());
                if (firstAw) begin
                    checkOutput("awlen", 32'(awlen), 32'd3);
                    checkOutput("awsize", 32'(awsize), 32'd2);
                    checkOutput("awburst", 32'(awburst), 32'd1);
                    checkOutput("awcache", 32'(awcache), 32'd3);
                    firstAw = 1'b0;
                end
            end
            if (wvalid && wready) begin
                if (beatTotal == 0) checkOutput("first_word", wdata, 32'h33441122);
                checkOutput("wlast", 32'(wlast), 32'(beatInBurst == LEN - 1));
                checkOutput("wstrb", 32'(wstrb), 32'hF);
                if (consecCheck && beatInBurst != 0) checkOutput("beat_gap", 32'(cycleCnt - lastBeatCycle), 32'd1);
                checkOutput("w_expected", 32'(expData.size() != 0), 32'd1);
                if (expData.size() != 0) checkOutput("wdata", wdata, expData.pop_front());
                lastBeatCycle = cycleCnt;
                beatTotal++;
                if (beatInBurst == LEN - 1) begin
                    beatInBurst = 0;
                    bPending    = 1'b1;
                end else begin
                    beatInBurst++;
                end
            end
            if (done) begin
                doneCnt++;
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Check every output that has a defined reset value.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        checkOutput({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        checkOutput({tag, "_wlast"}, 32'(wlast), 32'd0);
        checkOutput({tag, "_cs_n"}, 32'(lcdCsN), 32'd1);
        checkOutput({tag, "_rd_n"}, 32'(lcdRdN), 32'd1);
        checkOutput({tag, "_rs"}, 32'(lcdRs), 32'd1);
        checkOutput({tag, "_oe"}, 32'(lcdDataOe), 32'd1);
        checkOutput({tag, "_awaddr"}, awaddr, 32'd0);
    endtask

    // Reset the scoreboard for a new frame, then pulse start at the given base address.
    task automatic beginFrame(input logic [31:0] addr, input int errB, input bit wreadyOn);
        strobeCnt   = 0;
        beatTotal   = 0;
        beatInBurst = 0;
        doneCnt     = 0;
        burstIdx    = 0;
        errBurst    = errB;
        bPending    = 1'b0;
        firstAw     = 1'b1;
        consecCheck = wreadyOn;
        expData.delete();
        expAddr.delete();
        for (int b = 0; b < CYC; b++) expAddr.push_back(addr + 32'(16 * b));
        @(posedge clock);
        #1;
        start       = 1'b1;
        destAddress = addr;
        wready      = wreadyOn;
        @(posedge clock);
        #1;
        start      = 1'b0;
        startCycle = cycleCnt;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("err_cleared", 32'(err), 32'd0);
        checkOutput("oe_while_busy", 32'(lcdDataOe), 32'd0);
        checkOutput("rs_while_busy", 32'(lcdRs), 32'd1);
    endtask

    // Run one full frame. Options: a WREADY stall, a start pulse while busy,
    // and an expected final err value.
    task automatic applyStimulus(input logic [31:0] addr, input int errB, input int stall,
                                 input bit pulseBusy, input bit expectErr);
        int waited;
        beginFrame(addr, errB, stall == 0);
        if (stall > 0) begin
            repeat (stall) @(posedge clock);
            #1;
            checkOutput("stall_strobes", 32'(strobeCnt), 32'(FIFO_DEPTH * 4 + DUMMY));
            checkOutput("stall_busy", 32'(busy), 32'd1);
            checkOutput("stall_cs_n", 32'(lcdCsN), 32'd0);
            wready = 1'b1;
        end
        if (pulseBusy) begin
            repeat (150) @(posedge clock);
            #1;
            start       = 1'b1;
            destAddress = 32'h2000_0000;
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        waited = 0;
        while (doneCnt == 0 && waited < 20000) begin
            @(posedge clock);
            waited++;
        end
        repeat (3) @(posedge clock);
        #1;
        checkOutput("done_count", 32'(doneCnt), 32'd1);
        checkOutput("first_fall", 32'(firstFallCycle - startCycle), 32'(RD_LO + 1));
        checkOutput("strobes", 32'(strobeCnt), 32'(STROBES));
        checkOutput("beats", 32'(beatTotal), 32'(LEN * CYC));
        checkOutput("words_left", 32'(expData.size()), 32'd0);
        checkOutput("addrs_left", 32'(expAddr.size()), 32'd0);
        checkOutput("err_final", 32'(err), 32'(expectErr));
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_cs_n", 32'(lcdCsN), 32'd1);
        checkOutput("idle_oe", 32'(lcdDataOe), 32'd1);
    endtask

    // Assert reset in the middle of a frame. Every output must return to its
    // reset value immediately.
    task automatic resetMidFrame();
        beginFrame(32'h0800_0000, -1, 1'b1);
        repeat (200) @(posedge clock);
        @(negedge clock);
        #2;
        aresetn = 1'b0;
        #1;
        checkReset("midreset");
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        aresetn = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        aresetn     = 1'b0;
        start       = 1'b0;
        destAddress = 32'd0;
        awready     = 1'b1;
        wready      = 1'b1;
        lcdDataIn   = 8'h00;
        accWord     = 32'd0;
        strobeCnt   = 0;
        bPending    = 1'b0;
        errBurst    = -1;
        burstIdx    = 0;
        repeat (3) @(posedge clock);
        #1;
        checkReset("reset");
        @(negedge clock);
        #2;
        aresetn = 1'b1;
        repeat (2) @(posedge clock);

        $display("[TB] mid-frame reset, then a clean frame");
        resetMidFrame();
        applyStimulus(32'h1000_0000, -1, 0, 1'b0, 1'b0);

        $display("[TB] WREADY backpressure");
        applyStimulus(32'h3000_0000, -1, 2000, 1'b0, 1'b0);

        $display("[TB] SLVERR on burst 2 and start while busy");
        applyStimulus(32'h1000_0000, 1, 0, 1'b1, 1'b1);

        $display("[TB] address wrap, err cleared by start");
        applyStimulus(32'hFFFF_FFE0, -1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
